tdm_channel_link: RTL and testbench
===================================

// Module: tdm_channel_link
// PURPOSE
//  Parametrised, registered successor to the combinational 8-bit bit-transmission path.
//  Selects one WIDTH-bit channel field from a packed input bus and routes it into the
//  same slot of a packed output bus. Runs in manual mode (select from port) or scan mode
//  (internal counter sweeps all channels with programmable dwell).
//  Sits between parallel sources and sinks that share a single time-multiplexed link.
// PARAMETERS
//  CHANNELS  8  number of channel slots, >=2; need not be a power of two
//  WIDTH     1  bits per channel field
//  DWELL     1  scan mode: cycles each channel is held before advancing, >=1
//  HOLD      0  0: non-selected output slots cleared on each update; 1: slots retain last value
//  SELW      $clog2(CHANNELS)  derived; do not override
// PORTS
//  clk           in   1                clock, rising edge
//  rst_n         in   1                asynchronous reset, active low
//  i_data        in   CHANNELS*WIDTH   packed sources; channel k = i_data[k*WIDTH +: WIDTH]
//  i_en          in   1                level enable; 0 returns FSM to IDLE
//  i_mode        in   1                0 manual, 1 scan
//  i_sel         in   SELW             manual-mode channel index
//  o_data        out  CHANNELS*WIDTH   packed destination slots (registered)
//  o_cur_sel     out  SELW             index of the slot updated with o_valid
//  o_valid       out  1                1-cycle pulse: o_data slot o_cur_sel written this cycle
//  o_frame_done  out  1                1-cycle pulse, coincident with o_valid of the last channel in a scan
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE; all outputs 0; scan idx 0; dwell cnt 0.
//  - FSM states IDLE, MANUAL, SCAN. i_mode is sampled only in IDLE and at scan frame end.
//    IDLE: i_en=1 and i_mode=0 -> MANUAL; i_en=1 and i_mode=1 -> SCAN with idx=0, cnt=0.
//    MANUAL: issues i_sel every cycle. i_en=0 -> IDLE. i_mode change is ignored while in MANUAL.
//    SCAN: issues idx once per dwell window, on the cycle cnt==0. cnt counts 0..DWELL-1.
//      idx advances when cnt==DWELL-1. At idx==CHANNELS-1 with cnt==DWELL-1: frame end.
//      At frame end idx wraps to 0. Then i_en=0 -> IDLE; i_mode=0 -> MANUAL; else stay in SCAN.
//      i_en=0 mid-frame -> IDLE next cycle; the partial frame is abandoned; no o_frame_done.
//  - Two-stage pipeline, fixed latency 2:
//    - Stage 1 registers the issued index and field i_data[idx*WIDTH +: WIDTH].
//    - Stage 2 writes that field into o_data slot idx. In the same cycle it asserts
//      o_valid and drives o_cur_sel=idx.
//    - Issue at cycle t gives o_valid at t+2. Sampled data is i_data as of cycle t.
//  - HOLD=0: on each o_valid, all other slots -> 0. Between o_valid pulses o_data is held.
//  - HOLD=1: only the selected slot changes.
//  - Manual i_sel >= CHANNELS: nothing issued. No o_valid; o_data unchanged.
//  - IDLE issues nothing; in-flight stages drain normally (max 2 trailing o_valid).
//  - Scan DWELL=1: one o_valid per cycle, frame = CHANNELS cycles.
//    Scan DWELL=D: one o_valid per D cycles.
//  - Reset mid-operation: pipeline contents discarded; outputs 0 immediately.
// STRUCTURE
//  - Shared package tdm_link_pkg:
//    - state enum {IDLE, MANUAL, SCAN}
//    - MODE_MANUAL/MODE_SCAN constants
//    - function sel_width(n)
//  - Sub-module tdm_scan_ctr: owns idx/cnt, dwell and wrap logic. Outputs issue strobe,
//    idx, frame_end. Top holds FSM, mux stage, demux/write stage.
// TESTING
//  1. Reset values: assert rst_n=0 mid-run -> o_data=0, o_valid=0, o_frame_done=0 same cycle, FSM IDLE.
//  2. Manual, HOLD=0, CHANNELS=8, WIDTH=1, i_data=8'b1010_0110, i_sel=5
//     -> 2 cycles later o_data=8'b0010_0000, o_cur_sel=5, o_valid=1.
//  3. Scan, DWELL=1, i_data=8'hA5 constant, HOLD=1:
//     -> o_valid on 8 consecutive cycles, o_cur_sel 0..7.
//     -> o_frame_done with idx 7; o_data=8'hA5 after frame; idx wraps to 0.
//  4. Scan, DWELL=3, CHANNELS=5: o_valid every 3rd cycle; o_frame_done after 15 cycles.
//     Drop i_en at idx 2 -> no o_frame_done, IDLE, at most 2 trailing o_valid.
//  5. CHANNELS=6 manual, i_sel=7 -> no o_valid, o_data unchanged.
//     Mode flip to scan while in MANUAL -> ignored until i_en cycles through IDLE.
//  6. WIDTH=4, CHANNELS=4, HOLD=1, scan:
//     i_data changes at issue cycle of ch2 -> slot 2 holds value sampled at issue, not later value.

Source files
------------

// File: rtl/tdm_link_pkg.sv
// Shared types and helpers for the time-multiplexed channel link.
package tdm_link_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width of a channel index; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_scan_ctr.sv
// Scan sequencer: sweeps idx 0..CHANNELS-1, holding each index for DWELL cycles.
module tdm_scan_ctr #(
  parameter int CHANNELS = 8,
  parameter int DWELL    = 1,
  parameter int SELW     = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            issue,
  output logic [SELW-1:0] idx,
  output logic            frame_end
);

  localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [SELW-1:0] IDX_LAST = SELW'(CHANNELS - 1);
  localparam logic [SELW-1:0] IDX_ONE  = SELW'(1);

  logic [CNTW-1:0] cnt;
  logic            window_end;

  assign window_end = (cnt == CNT_LAST);
  assign issue      = run && (cnt == '0);
  assign frame_end  = run && window_end && (idx == IDX_LAST);

  // Dropping run parks the sequencer at channel 0 so every scan starts a fresh frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
    end else if (!run) begin
      idx <= '0;
      cnt <= '0;
    end else if (window_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + IDX_ONE;
    end else begin
      cnt <= cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/tdm_channel_link.sv
// Registered channel router: picks one WIDTH-bit field (manual or scanned index)
// and writes it into the same slot of the output bus two cycles later.
module tdm_channel_link
  import tdm_link_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int WIDTH    = 1,
  parameter int DWELL    = 1,
  parameter int HOLD     = 0,
  parameter int SELW     = sel_width(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] i_data,
  input  logic                      i_en,
  input  logic                      i_mode,
  input  logic [SELW-1:0]           i_sel,
  output logic [CHANNELS*WIDTH-1:0] o_data,
  output logic [SELW-1:0]           o_cur_sel,
  output logic                      o_valid,
  output logic                      o_frame_done,
  output state_t                    dbg_state
);

  localparam logic [SELW:0]   CH_LIMIT = (SELW + 1)'(CHANNELS);
  localparam logic [SELW-1:0] IDX_LAST = SELW'(CHANNELS - 1);

  state_t state, state_next;

  logic             scan_issue, scan_frame_end;
  logic [SELW-1:0]  scan_idx;
  logic             iss_valid, iss_last;
  logic [SELW-1:0]  iss_idx;
  logic [WIDTH-1:0] iss_field;

  logic             s1_valid, s1_last;
  logic [SELW-1:0]  s1_idx;
  logic [WIDTH-1:0] s1_field;

  logic [CHANNELS*WIDTH-1:0] data_next;

  tdm_scan_ctr #(
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL),
    .SELW     (SELW)
  ) u_scan_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (state == SCAN),
    .issue     (scan_issue),
    .idx       (scan_idx),
    .frame_end (scan_frame_end)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // i_mode only matters when leaving IDLE or at the end of a complete scan frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_en) state_next = (i_mode == MODE_SCAN) ? SCAN : MANUAL;
      MANUAL:  if (!i_en) state_next = IDLE;
      SCAN: begin
        if (!i_en)                                        state_next = IDLE;
        else if (scan_frame_end && i_mode == MODE_MANUAL) state_next = MANUAL;
      end
      default: state_next = IDLE;
    endcase
  end

  assign dbg_state = state;

  always_comb begin
    iss_valid = 1'b0;
    iss_last  = 1'b0;
    iss_idx   = scan_idx;
    case (state)
      MANUAL: begin
        iss_valid = ({1'b0, i_sel} < CH_LIMIT);
        iss_idx   = i_sel;
      end
      SCAN: begin
        iss_valid = scan_issue;
        iss_last  = scan_issue && (scan_idx == IDX_LAST);
      end
      default: ;
    endcase
  end

  always_comb begin
    iss_field = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (iss_idx == SELW'(k)) iss_field = i_data[k*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_idx   <= '0;
      s1_field <= '0;
    end else begin
      s1_valid <= iss_valid;
      s1_last  <= iss_last;
      if (iss_valid) begin
        s1_idx   <= iss_idx;
        s1_field <= iss_field;
      end
    end
  end

  // With HOLD=0 every write starts from a cleared bus, so only the new slot is non-zero.
  always_comb begin
    data_next = (HOLD != 0) ? o_data : '0;
    for (int k = 0; k < CHANNELS; k++)
      if (s1_idx == SELW'(k)) data_next[k*WIDTH +: WIDTH] = s1_field;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data       <= '0;
      o_cur_sel    <= '0;
      o_valid      <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_valid      <= s1_valid;
      o_frame_done <= s1_last;
      if (s1_valid) begin
        o_data    <= data_next;
        o_cur_sel <= s1_idx;
      end
    end
  end

endmodule

// File: tb/tb_tdm_channel_link.sv
// Directed bench for tdm_channel_link: five parameterisations driven in turn on one clock.
module tb_tdm_channel_link;
  import tdm_link_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // a: CH=8 W=1 DWELL=1 HOLD=0
  logic a_en, a_mode, a_valid, a_done;
  logic [2:0] a_sel, a_cur;
  logic [7:0] a_data, a_odata;
  state_t a_state;
  // b: CH=8 W=1 DWELL=1 HOLD=1
  logic b_en, b_mode, b_valid, b_done;
  logic [2:0] b_sel, b_cur;
  logic [7:0] b_data, b_odata;
  state_t b_state;
  // c: CH=5 W=1 DWELL=3 HOLD=0
  logic c_en, c_mode, c_valid, c_done;
  logic [2:0] c_sel, c_cur;
  logic [4:0] c_data, c_odata;
  state_t c_state;
  // d: CH=6 W=1 DWELL=1 HOLD=0
  logic d_en, d_mode, d_valid, d_done;
  logic [2:0] d_sel, d_cur;
  logic [5:0] d_data, d_odata;
  state_t d_state;
  // e: CH=4 W=4 DWELL=1 HOLD=1
  logic e_en, e_mode, e_valid, e_done;
  logic [1:0] e_sel, e_cur;
  logic [15:0] e_data, e_odata;
  state_t e_state;

  tdm_channel_link #(.CHANNELS(8), .WIDTH(1), .DWELL(1), .HOLD(0)) u_a (
    .clk(clk), .rst_n(rst_n), .i_data(a_data), .i_en(a_en), .i_mode(a_mode), .i_sel(a_sel),
    .o_data(a_odata), .o_cur_sel(a_cur), .o_valid(a_valid), .o_frame_done(a_done), .dbg_state(a_state));
  tdm_channel_link #(.CHANNELS(8), .WIDTH(1), .DWELL(1), .HOLD(1)) u_b (
    .clk(clk), .rst_n(rst_n), .i_data(b_data), .i_en(b_en), .i_mode(b_mode), .i_sel(b_sel),
    .o_data(b_odata), .o_cur_sel(b_cur), .o_valid(b_valid), .o_frame_done(b_done), .dbg_state(b_state));
  tdm_channel_link #(.CHANNELS(5), .WIDTH(1), .DWELL(3), .HOLD(0)) u_c (
    .clk(clk), .rst_n(rst_n), .i_data(c_data), .i_en(c_en), .i_mode(c_mode), .i_sel(c_sel),
    .o_data(c_odata), .o_cur_sel(c_cur), .o_valid(c_valid), .o_frame_done(c_done), .dbg_state(c_state));
  tdm_channel_link #(.CHANNELS(6), .WIDTH(1), .DWELL(1), .HOLD(0)) u_d (
    .clk(clk), .rst_n(rst_n), .i_data(d_data), .i_en(d_en), .i_mode(d_mode), .i_sel(d_sel),
    .o_data(d_odata), .o_cur_sel(d_cur), .o_valid(d_valid), .o_frame_done(d_done), .dbg_state(d_state));
  tdm_channel_link #(.CHANNELS(4), .WIDTH(4), .DWELL(1), .HOLD(1)) u_e (
    .clk(clk), .rst_n(rst_n), .i_data(e_data), .i_en(e_en), .i_mode(e_mode), .i_sel(e_sel),
    .o_data(e_odata), .o_cur_sel(e_cur), .o_valid(e_valid), .o_frame_done(e_done), .dbg_state(e_state));

  typedef struct {
    logic [7:0] data;
    logic [2:0] sel;
    logic [7:0] exp_data;
  } man_vec_t;

  man_vec_t man_vecs[6];
  logic [4:0] c_exp_data[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    man_vecs[0] = '{8'b1010_0110, 3'd5, 8'b0010_0000};
    man_vecs[1] = '{8'b1010_0110, 3'd0, 8'b0000_0000};
    man_vecs[2] = '{8'hFF,        3'd7, 8'h80};
    man_vecs[3] = '{8'h08,        3'd3, 8'h08};
    man_vecs[4] = '{8'hF7,        3'd3, 8'h00};
    man_vecs[5] = '{8'h01,        3'd2, 8'h00};
    // c_data = 5'b10110: channels 1, 2 and 4 carry a one
    c_exp_data = '{5'b00000, 5'b00010, 5'b00100, 5'b00000, 5'b10000};

    rst_n = 1'b0;
    {a_en, a_mode, a_sel, a_data} = '0;
    {b_en, b_mode, b_sel, b_data} = '0;
    {c_en, c_mode, c_sel, c_data} = '0;
    {d_en, d_mode, d_sel, d_data} = '0;
    {e_en, e_mode, e_sel, e_data} = '0;
    tick();
    tick();
    check("reset_data", a_odata, 8'h00);
    check("reset_valid", a_valid, 1'b0);
    check("reset_done", a_done, 1'b0);
    check("reset_state", a_state, IDLE);
    rst_n = 1'b1;
    tick();

    // manual mode table, HOLD=0
    a_en = 1'b1; a_mode = MODE_MANUAL; a_sel = 3'd5; a_data = 8'b1010_0110;
    tick();
    check("a_enter_manual", a_state, MANUAL);
    for (int i = 0; i < 6; i++) begin
      a_data = man_vecs[i].data;
      a_sel  = man_vecs[i].sel;
      tick();
      tick();
      check("a_man_data", a_odata, man_vecs[i].exp_data);
      check("a_man_sel", a_cur, man_vecs[i].sel);
      check("a_man_valid", a_valid, 1'b1);
    end

    // mode flip in MANUAL is ignored until i_en passes through IDLE
    a_mode = MODE_SCAN;
    repeat (3) tick();
    check("a_flip_state", a_state, MANUAL);
    check("a_flip_sel", a_cur, 3'd2);
    a_en = 1'b0;
    tick();
    check("a_idle", a_state, IDLE);
    a_en = 1'b1; a_data = 8'hFF;
    tick();
    check("a_scan_entry", a_state, SCAN);
    repeat (3) tick();
    check("a_prereset_valid", a_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_data", a_odata, 8'h00);
    check("midrst_valid", a_valid, 1'b0);
    check("midrst_done", a_done, 1'b0);
    check("midrst_state", a_state, IDLE);
    a_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // scan DWELL=1 HOLD=1, constant A5
    b_data = 8'hA5; b_en = 1'b1; b_mode = MODE_SCAN;
    for (int k = 0; k < 8; k++) exp_q.push_back(32'(k));
    exp_q.push_back(32'd0);
    tick();
    check("b_enter_scan", b_state, SCAN);
    tick();
    check("b_latency_valid", b_valid, 1'b0);
    for (int n = 0; n < 9; n++) begin
      tick();
      check("b_valid", b_valid, 1'b1);
      if (exp_q.size() > 0) check("b_cur_sel", b_cur, exp_q.pop_front());
      check("b_done", b_done, (n == 7));
      if (n == 7) check("b_frame_data", b_odata, 8'hA5);
    end
    check("b_queue_empty", exp_q.size(), 0);
    b_en = 1'b0;
    tick();
    check("b_trail1_valid", b_valid, 1'b1);
    check("b_trail1_sel", b_cur, 3'd1);
    tick();
    check("b_trail2_valid", b_valid, 1'b1);
    check("b_trail2_sel", b_cur, 3'd2);
    tick();
    check("b_drained_valid", b_valid, 1'b0);
    check("b_drained_state", b_state, IDLE);
    check("b_drained_data", b_odata, 8'hA5);

    // scan DWELL=3 over 5 channels, then abandon the second frame at idx 2
    c_data = 5'b10110; c_en = 1'b1; c_mode = MODE_SCAN;
    for (int n = 1; n <= 28; n++) begin
      tick();
      if (n <= 22) begin
        check("c_valid", c_valid, (n % 3 == 0));
        check("c_done", c_done, (n == 15));
        if (n % 3 == 0) begin
          check("c_cur_sel", c_cur, 32'((n / 3 - 1) % 5));
          check("c_data", c_odata, c_exp_data[(n / 3 - 1) % 5]);
        end
        if (n == 22) c_en = 1'b0;
      end else begin
        check("c_state_idle", c_state, IDLE);
        check("c_trail_valid", c_valid, (n == 24));
        check("c_no_done", c_done, 1'b0);
        if (n == 24) check("c_trail_sel", c_cur, 3'd2);
      end
    end

    // CHANNELS=6: out-of-range selects are dropped
    d_en = 1'b1; d_mode = MODE_MANUAL; d_sel = 3'd2; d_data = 6'b000100;
    repeat (3) tick();
    check("d_first_valid", d_valid, 1'b1);
    check("d_first_data", d_odata, 6'b000100);
    d_sel = 3'd7;
    tick();
    check("d_inflight_valid", d_valid, 1'b1);
    tick();
    check("d_sel7_valid", d_valid, 1'b0);
    check("d_sel7_data", d_odata, 6'b000100);
    d_sel = 3'd6;
    repeat (2) tick();
    check("d_sel6_valid", d_valid, 1'b0);
    check("d_sel6_data", d_odata, 6'b000100);
    check("d_sel6_cur", d_cur, 3'd2);
    d_mode = MODE_SCAN; d_sel = 3'd1; d_data = 6'b000010;
    repeat (2) tick();
    check("d_flip_state", d_state, MANUAL);
    check("d_flip_valid", d_valid, 1'b1);
    check("d_flip_cur", d_cur, 3'd1);
    check("d_flip_data", d_odata, 6'b000010);
    d_en = 1'b0;
    tick();
    check("d_idle", d_state, IDLE);
    d_en = 1'b1;
    tick();
    check("d_scan_after_idle", d_state, SCAN);
    d_en = 1'b0;

    // WIDTH=4 HOLD=1: slot 2 keeps the value present during its issue cycle
    e_data = 16'h4321; e_en = 1'b1; e_mode = MODE_SCAN;
    repeat (3) tick();
    check("e_slot0_sel", e_cur, 2'd0);
    check("e_slot0_data", e_odata, 16'h0001);
    tick();
    check("e_slot1_data", e_odata, 16'h0021);
    e_data = 16'hFFFF;
    tick();
    check("e_slot2_sel", e_cur, 2'd2);
    check("e_slot2_data", e_odata, 16'h0321);
    tick();
    check("e_slot3_data", e_odata, 16'hF321);
    check("e_frame_done", e_done, 1'b1);
    tick();
    check("e_wrap_sel", e_cur, 2'd0);
    check("e_wrap_data", e_odata, 16'hF32F);
    check("e_wrap_done", e_done, 1'b0);
    e_en = 1'b0;
    repeat (3) tick();
    check("e_idle", e_state, IDLE);
    check("e_idle_valid", e_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
